// File: rtl/keccak_pkg.sv
// rtl/keccak_pkg.sv - shared lane width, padding constants and absorb FSM states
// Contents: LANE_W, DOMAIN_SHA3 / DOMAIN_SHAKE domain bytes, PAD_LAST final pad byte,
// and absorb_state_e (IDLE, COLLECT, FIRE, WAIT_PERM).
package keccak_pkg;

  localparam int LANE_W = 64;

  localparam logic [7:0] DOMAIN_SHA3  = 8'h06;
  localparam logic [7:0] DOMAIN_SHAKE = 8'h1F;
  localparam logic [7:0] PAD_LAST     = 8'h80;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    FIRE,
    WAIT_PERM
  } absorb_state_e;

endpackage

// File: rtl/keccak_pad_lane.sv
// rtl/keccak_pad_lane.sv - combinational pad10*1 lane builder
// Ports:
//   data      in  64  message lane, little-endian bytes
//   n_bytes   in  4   valid bytes (0..8); bytes at and above n_bytes are zeroed
//   domain    in  8   domain byte OR'd into byte n_bytes (no effect when n_bytes == 8)
//   is_final  in  1   lane is the last rate lane: byte 7 gets 8'h80 OR'd in
//   padded    out 64  padded lane
module keccak_pad_lane
  import keccak_pkg::*;
(
  input  logic [LANE_W-1:0] data,
  input  logic [3:0]        n_bytes,
  input  logic [7:0]        domain,
  input  logic              is_final,
  output logic [LANE_W-1:0] padded
);

  for (genvar g = 0; g < 8; g++) begin : g_byte
    // Domain and final-pad bits are OR'd so they can share byte 7 of a one-lane rate.
    assign padded[8*g +: 8] = ((4'(g) <  n_bytes) ? data[8*g +: 8] : 8'h00)
                            | ((4'(g) == n_bytes) ? domain         : 8'h00)
                            | ((g == 7 && is_final) ? PAD_LAST     : 8'h00);
  end

endmodule

// File: rtl/keccak_absorb.sv
// rtl/keccak_absorb.sv - Keccak absorb front-end: lane packing, pad10*1, permutation handshake
// Optional feature macro: KECCAK_ABSORB_DOMAIN_IN_EN adds domain_i (sampled on the first
// accepted lane of a message) in place of the DOMAIN parameter.
// Ports:
//   clk_i, rst_i (async, active-high)
//   lane_valid_i / lane_ready_o / lane_data_i / lane_last_i / lane_bytes_i  - lane stream in
//   blk_o        rate block, lane k at [64k+63:64k]
//   start_o / dp_ready_i  - permutation start handshake
//   perm_done_i  permutation finished pulse
//   msg_done_o   pulse after the final block's permutation
//   busy_o       not in IDLE
//   domain_i     (KECCAK_ABSORB_DOMAIN_IN_EN only) runtime domain byte
module keccak_absorb
  import keccak_pkg::*;
#(
  parameter int         LANE_W     = 64,
  parameter int         RATE_LANES = 17,
  parameter logic [7:0] DOMAIN     = DOMAIN_SHA3
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         lane_valid_i,
  input  logic [LANE_W-1:0]            lane_data_i,
  input  logic                         lane_last_i,
  input  logic [3:0]                   lane_bytes_i,
  output logic                         lane_ready_o,
  output logic [RATE_LANES*LANE_W-1:0] blk_o,
  output logic                         start_o,
  input  logic                         dp_ready_i,
  input  logic                         perm_done_i,
  output logic                         msg_done_o,
`ifdef KECCAK_ABSORB_DOMAIN_IN_EN
  input  logic [7:0]                   domain_i,
`endif
  output logic                         busy_o
);

  localparam logic [4:0] RL    = 5'(RATE_LANES);
  localparam logic [4:0] RL_M1 = 5'(RATE_LANES - 1);

  absorb_state_e     state_q;
  logic [4:0]        cnt_q;
  logic              final_q;
  logic              pad_pend_q;
  logic [LANE_W-1:0] lane_q [RATE_LANES];

  logic [3:0]        n_bytes;
  logic              full_last;
  logic              pad_defer;
  logic              accept;
  logic              pad_only;
  logic [7:0]        dom_eff;
  logic [LANE_W-1:0] pad_data;
  logic [3:0]        pad_bytes;
  logic              pad_final;
  logic [LANE_W-1:0] pad_out;

`ifdef KECCAK_ABSORB_DOMAIN_IN_EN
  logic       first_q;
  logic [7:0] dom_q;
  // The first lane's own padding (single-lane message) must already see domain_i.
  assign dom_eff = first_q ? domain_i : dom_q;
`else
  assign dom_eff = DOMAIN;
`endif

  assign n_bytes   = (lane_bytes_i > 4'd8) ? 4'd8 : lane_bytes_i;
  assign full_last = (n_bytes == 4'd8);
  // A full final lane that also fills the rate leaves no room: padding goes in a later block.
  assign pad_defer = full_last && (cnt_q == RL_M1);
  assign accept    = lane_valid_i && lane_ready_o;

  // One pad-lane builder serves both the in-message final lane and the pad-only block.
  assign pad_only  = (state_q == WAIT_PERM);
  assign pad_data  = (pad_only || full_last) ? '0 : lane_data_i;
  assign pad_bytes = (pad_only || full_last) ? 4'd0 : n_bytes;
  assign pad_final = pad_only  ? (RATE_LANES == 1)
                   : full_last ? (cnt_q + 5'd1 == RL_M1)
                   :             (cnt_q == RL_M1);

  keccak_pad_lane u_pad (
    .data     (pad_data),
    .n_bytes  (pad_bytes),
    .domain   (dom_eff),
    .is_final (pad_final),
    .padded   (pad_out)
  );

  assign lane_ready_o = (state_q == COLLECT) && (cnt_q < RL);
  assign start_o      = (state_q == FIRE);
  assign busy_o       = (state_q != IDLE);

  for (genvar k = 0; k < RATE_LANES; k++) begin : g_blk
    assign blk_o[k*LANE_W +: LANE_W] = lane_q[k];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      final_q    <= 1'b0;
      pad_pend_q <= 1'b0;
      msg_done_o <= 1'b0;
      for (int k = 0; k < RATE_LANES; k++) lane_q[k] <= '0;
`ifdef KECCAK_ABSORB_DOMAIN_IN_EN
      first_q    <= 1'b0;
      dom_q      <= '0;
`endif
    end else begin
      msg_done_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (lane_valid_i) begin
            state_q <= COLLECT;
`ifdef KECCAK_ABSORB_DOMAIN_IN_EN
            first_q <= 1'b1;
`endif
          end
        end
        COLLECT: begin
          if (accept) begin
`ifdef KECCAK_ABSORB_DOMAIN_IN_EN
            first_q <= 1'b0;
            if (first_q) dom_q <= domain_i;
`endif
            cnt_q <= cnt_q + 5'd1;
            // Lanes above cnt_q are already zero, so only the written lanes need updating.
            for (int k = 0; k < RATE_LANES; k++) begin
              if (5'(k) == cnt_q)
                lane_q[k] <= (lane_last_i && !full_last) ? pad_out : lane_data_i;
              else if (lane_last_i && full_last && 5'(k) == cnt_q + 5'd1)
                lane_q[k] <= pad_out;
              else if (lane_last_i && !pad_defer && k == RATE_LANES - 1)
                lane_q[k] <= {PAD_LAST, {(LANE_W-8){1'b0}}};
            end
            if (lane_last_i) begin
              state_q    <= FIRE;
              final_q    <= !pad_defer;
              pad_pend_q <= pad_defer;
            end else if (cnt_q == RL_M1) begin
              state_q <= FIRE;
              final_q <= 1'b0;
            end
          end
        end
        FIRE: begin
          if (dp_ready_i) state_q <= WAIT_PERM;
        end
        WAIT_PERM: begin
          if (perm_done_i) begin
            if (pad_pend_q) begin
              for (int k = 0; k < RATE_LANES; k++) begin
                if (k == 0)                   lane_q[k] <= pad_out;
                else if (k == RATE_LANES - 1) lane_q[k] <= {PAD_LAST, {(LANE_W-8){1'b0}}};
                else                          lane_q[k] <= '0;
              end
              pad_pend_q <= 1'b0;
              final_q    <= 1'b1;
              state_q    <= FIRE;
            end else begin
              for (int k = 0; k < RATE_LANES; k++) lane_q[k] <= '0;
              cnt_q      <= '0;
              msg_done_o <= final_q;
              state_q    <= final_q ? IDLE : COLLECT;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
